// File: rtl/bus_stim_gen.sv
// Burst pattern generator: one accepted START produces BURST_LEN registered words
// on A/B/C/D (count, walking-one, LFSR or checker), then a single DONE pulse.
module bus_stim_gen #(
    parameter int          BURST_LEN = 16,
    parameter logic [31:0] SEED      = 32'h0000_0001
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [1:0]  MODE,
    output logic        A,
    output logic [3:0]  B,
    output logic [7:0]  C,
    output logic [31:0] D,
    output logic        BUSY,
    output logic        DONE,
    output logic [7:0]  COUNT
);

    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h0000_0001 : SEED;
    localparam logic [31:0] POLY     = 32'h8020_0003;
    localparam logic [7:0]  LAST     = 8'(BURST_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_lfsr, w_lfsr_nxt;
    logic [1:0]  r_mode, w_mode_nxt;
    logic        w_busy, w_done;
    logic [44:0] w_word;
    logic [44:0] r_word;
    logic        r_busy, r_done;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? POLY : 32'h0);
    endfunction

    // Packed as {A, B, C, D} for word index i with LFSR value l.
    function automatic logic [44:0] pattern(input logic [1:0] m, input logic [7:0] i,
                                            input logic [31:0] l);
        logic [44:0] w;
        case (m)
            2'b00:   w = {i[0], i[3:0], i, {24'h0, i}};
            2'b01:   w = {i[0], 4'h1 << i[1:0], 8'h01 << i[2:0], 32'h1 << i[4:0]};
            2'b10:   w = {l[0], l[3:0], l[7:0], l};
            default: w = i[0] ? {1'b1, 4'h5, 8'h55, 32'h5555_5555}
                              : {1'b0, 4'hA, 8'hAA, 32'hAAAA_AAAA};
        endcase
        return w;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lfsr_nxt  = r_lfsr;
        w_mode_nxt  = r_mode;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_nxt = S_RUN;
                    w_mode_nxt  = MODE;
                    w_lfsr_nxt  = SEED_EFF;
                    w_cnt_nxt   = 8'd0;
                    w_busy      = 1'b1;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = 8'd0;
                    w_done      = 1'b1;
                end else begin
                    w_cnt_nxt  = r_cnt + 8'd1;
                    w_lfsr_nxt = lfsr_step(r_lfsr);
                    w_busy     = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // The word shown next cycle is derived from the next-cycle index/LFSR/mode.
        w_word = w_busy ? pattern(w_mode_nxt, w_cnt_nxt, w_lfsr_nxt) : 45'h0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_word  <= 45'h0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_word  <= w_word;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    // Mode and LFSR are reloaded on every accept, so they need no reset.
    always_ff @(posedge CLK) begin
        r_lfsr <= w_lfsr_nxt;
        r_mode <= w_mode_nxt;
    end

    assign A     = r_word[44];
    assign B     = r_word[43:40];
    assign C     = r_word[39:32];
    assign D     = r_word[31:0];
    assign BUSY  = r_busy;
    assign DONE  = r_done;
    assign COUNT = r_cnt;

endmodule

// File: tb/tb_bus_stim_gen.sv
// Bench for bus_stim_gen: four instances (burst lengths 16, 4, 1, 256) share one
// stimulus stream and are compared against a schedule-based reference model.
module tb_bus_stim_gen;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [1:0]  MODE = 2'b00;

    logic        A_o     [4];
    logic [3:0]  B_o     [4];
    logic [7:0]  C_o     [4];
    logic [31:0] D_o     [4];
    logic        BUSY_o  [4];
    logic        DONE_o  [4];
    logic [7:0]  COUNT_o [4];

    int          n_checks = 0;
    int          n_errors = 0;

    localparam int          BL_T   [4] = '{16, 4, 1, 256};
    localparam logic [31:0] SEED_T [4] = '{32'h0000_0001, 32'h0000_0000,
                                           32'hDEAD_BEEF, 32'h1234_5678};

    always #5 CLK = ~CLK;

    bus_stim_gen #(.BURST_LEN(16), .SEED(32'h0000_0001)) u_dut0 (
        .CLK(CLK), .RST(RST), .START(START), .MODE(MODE),
        .A(A_o[0]), .B(B_o[0]), .C(C_o[0]), .D(D_o[0]),
        .BUSY(BUSY_o[0]), .DONE(DONE_o[0]), .COUNT(COUNT_o[0]));
    bus_stim_gen #(.BURST_LEN(4), .SEED(32'h0000_0000)) u_dut1 (
        .CLK(CLK), .RST(RST), .START(START), .MODE(MODE),
        .A(A_o[1]), .B(B_o[1]), .C(C_o[1]), .D(D_o[1]),
        .BUSY(BUSY_o[1]), .DONE(DONE_o[1]), .COUNT(COUNT_o[1]));
    bus_stim_gen #(.BURST_LEN(1), .SEED(32'hDEAD_BEEF)) u_dut2 (
        .CLK(CLK), .RST(RST), .START(START), .MODE(MODE),
        .A(A_o[2]), .B(B_o[2]), .C(C_o[2]), .D(D_o[2]),
        .BUSY(BUSY_o[2]), .DONE(DONE_o[2]), .COUNT(COUNT_o[2]));
    bus_stim_gen #(.BURST_LEN(256), .SEED(32'h1234_5678)) u_dut3 (
        .CLK(CLK), .RST(RST), .START(START), .MODE(MODE),
        .A(A_o[3]), .B(B_o[3]), .C(C_o[3]), .D(D_o[3]),
        .BUSY(BUSY_o[3]), .DONE(DONE_o[3]), .COUNT(COUNT_o[3]));

    // Reference model: each instance remembers the edge of its last accept.
    logic [31:0] lfsr_tab [4][256];
    int          edge_no = 0;
    int          k_acc [4];
    bit          act   [4];
    logic [1:0]  lmode [4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    task automatic build_tables();
        for (int n = 0; n < 4; n++) begin
            logic [31:0] t;
            t = (SEED_T[n] == 32'h0) ? 32'h1 : SEED_T[n];
            for (int i = 0; i < 256; i++) begin
                lfsr_tab[n][i] = t;
                t = (t >> 1) ^ (t[0] ? 32'h8020_0003 : 32'h0);
            end
        end
    endtask

    task automatic exp_word(input int n, input logic [1:0] m, input int i,
                            output logic a, output logic [3:0] b,
                            output logic [7:0] c, output logic [31:0] d);
        case (m)
            2'd0: begin d = 32'(i); end
            2'd1: begin d = 32'h1 << (i % 32); c = 8'(1 << (i % 8)); b = 4'(1 << (i % 4)); end
            2'd2: begin d = lfsr_tab[n][i]; end
            default: d = (i % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
        endcase
        if (m != 2'd1) begin
            c = d[7:0];
            b = d[3:0];
        end
        a = (m == 2'd2) ? d[0] : ((i % 2) == 1);
    endtask

    task automatic step(input logic rst, input logic st, input logic [1:0] md);
        RST   = rst;
        START = st;
        MODE  = md;
        @(posedge CLK);
        edge_no++;
        for (int n = 0; n < 4; n++) begin
            if (rst) act[n] = 1'b0;
            else if (st && (!act[n] || (edge_no - k_acc[n]) >= BL_T[n] + 2)) begin
                act[n]   = 1'b1;
                k_acc[n] = edge_no;
                lmode[n] = md;
            end
        end
        #1;
        for (int n = 0; n < 4; n++) begin
            logic ea, eb_busy, edn;
            logic [3:0] eb;
            logic [7:0] ec, ecnt;
            logic [31:0] ed;
            int off;
            ea = 0; eb = 0; ec = 0; ed = 0; eb_busy = 0; edn = 0; ecnt = 0;
            off = edge_no - k_acc[n];
            if (act[n] && off < BL_T[n]) begin
                exp_word(n, lmode[n], off, ea, eb, ec, ed);
                eb_busy = 1'b1;
                ecnt    = 8'(off);
            end else if (act[n] && off == BL_T[n]) begin
                edn = 1'b1;
            end
            chk($sformatf("D%0d", n),     64'(D_o[n]),     64'(ed));
            chk($sformatf("C%0d", n),     64'(C_o[n]),     64'(ec));
            chk($sformatf("B%0d", n),     64'(B_o[n]),     64'(eb));
            chk($sformatf("A%0d", n),     64'(A_o[n]),     64'(ea));
            chk($sformatf("BUSY%0d", n),  64'(BUSY_o[n]),  64'(eb_busy));
            chk($sformatf("DONE%0d", n),  64'(DONE_o[n]),  64'(edn));
            chk($sformatf("COUNT%0d", n), 64'(COUNT_o[n]), 64'(ecnt));
        end
    endtask

    initial begin
        build_tables();
        for (int n = 0; n < 4; n++) begin
            act[n] = 1'b0; k_acc[n] = 0; lmode[n] = 2'b00;
        end

        // Reset with START held, then a count burst.
        step(1'b1, 1'b1, 2'd0);
        step(1'b1, 1'b1, 2'd0);
        step(1'b0, 1'b1, 2'd0);
        chk("t2_word0", 64'(D_o[1]), 64'd0);
        for (int i = 1; i < 4; i++) begin
            step(1'b0, 1'b0, 2'd0);
            chk("t2_word", 64'(D_o[1]), 64'(i));
        end
        step(1'b0, 1'b0, 2'd3);
        chk("t2_done", 64'(DONE_o[1]), 64'd1);
        chk("t2_busy", 64'(BUSY_o[1]), 64'd0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 2'd0);

        // Walking one on the 16-word instance.
        step(1'b0, 1'b1, 2'd1);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 2'd2);
        chk("t3_w9_D", 64'(D_o[0]), 64'h200);
        chk("t3_w9_C", 64'(C_o[0]), 64'h02);
        chk("t3_w9_B", 64'(B_o[0]), 64'h2);
        chk("t3_w9_A", 64'(A_o[0]), 64'h1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 2'd0);
        chk("t3_w15_D", 64'(D_o[0]), 64'h8000);
        chk("t3_w15_C", 64'(C_o[0]), 64'h80);
        chk("t3_w15_B", 64'(B_o[0]), 64'h8);
        chk("t3_w15_A", 64'(A_o[0]), 64'h1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'd0);

        // LFSR words, then reset at word 2 and a fresh start.
        step(1'b0, 1'b1, 2'd2);
        chk("t4_w0", 64'(D_o[0]), 64'h0000_0001);
        step(1'b0, 1'b0, 2'd0);
        chk("t4_w1", 64'(D_o[0]), 64'h8020_0003);
        step(1'b0, 1'b0, 2'd0);
        chk("t4_w2", 64'(D_o[0]), 64'hC030_0002);
        step(1'b1, 1'b0, 2'd0);
        chk("t6_rst_D", 64'(D_o[0]), 64'd0);
        step(1'b0, 1'b0, 2'd0);
        chk("t6_nodone", 64'(DONE_o[0]), 64'd0);
        step(1'b0, 1'b1, 2'd2);
        chk("t6_restart", 64'(D_o[0]), 64'h0000_0001);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 2'd0);

        // START held high through several checker bursts.
        for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 2'd3);

        // Randomized traffic, including mode changes mid-burst and rare resets.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                 2'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 2'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
